// File: rtl/axi_stream_strip_header_if.sv
// Bundles every stream and sideband signal of the header stripper.
//   slave  : the stripping block (consumes input stream and strip config,
//            produces payload stream and extracted header)
//   master : the environment driving and receiving those streams
// Signals:
//   valid_in/data_in/keep_in/last_in/ready_in       input stream (header + payload)
//   valid_out/data_out/keep_out/last_out/ready_out  payload stream, header removed
//   valid_strip/keep_strip/ready_strip              per-packet header length config
//   header_out/keep_header/header_valid             extracted header, LSB-aligned
interface axi_stream_strip_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_strip;
  logic [DATA_BYTE_WD-1:0] keep_strip;
  logic                    ready_strip;

  logic [DATA_WD-1:0]      header_out;
  logic [DATA_BYTE_WD-1:0] keep_header;
  logic                    header_valid;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, ready_out, valid_strip, keep_strip,
    output ready_in, valid_out, data_out, keep_out, last_out, ready_strip,
           header_out, keep_header, header_valid
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, ready_out, valid_strip, keep_strip,
    input  ready_in, valid_out, data_out, keep_out, last_out, ready_strip,
           header_out, keep_header, header_valid
  );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Removes a per-packet header of n bytes (n = popcount(keep_strip), 0..DATA_BYTE_WD)
// from the front of an MSB-first AXI stream packet, realigning the payload.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  axi_stream_strip_header_if.slave (input stream, output stream,
//        strip config handshake, extracted header)
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                      clk,
  input logic                      rst,
  axi_stream_strip_header_if.slave bus
);

  // One extra bit so a count can hold DATA_BYTE_WD itself.
  localparam int CntW = BYTE_CNT_WD + 1;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   sum_t;
  localparam sum_t FullSum = sum_t'(DATA_BYTE_WD);

  typedef enum logic [1:0] {StIdle, StHdr, StBody, StFlush} state_t;

  function automatic cnt_t popcount(input logic [DATA_BYTE_WD-1:0] k);
    cnt_t c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + cnt_t'(k[i]);
    return c;
  endfunction

  // MSB-aligned contiguous keep for c valid bytes.
  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input cnt_t c);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (i < int'(c));
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] mask_of(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t                  r_state;
  logic                    r_ready_strip;
  cnt_t                    r_n;
  logic [DATA_BYTE_WD-1:0] r_keep_strip;
  logic [DATA_WD-1:0]      r_res;     // residual bytes, MSB-aligned, zero below r_cnt
  cnt_t                    r_cnt;     // residual byte count
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;
  logic [DATA_WD-1:0]      r_header_out;
  logic [DATA_BYTE_WD-1:0] r_keep_header;
  logic                    r_header_valid;

  logic                    w_out_free;
  cnt_t                    w_strip_n;
  cnt_t                    w_in_cnt;
  logic [DATA_WD-1:0]      w_hdr_data;
  logic [DATA_WD-1:0]      w_hdr_res;
  cnt_t                    w_hdr_cnt;
  logic [DATA_WD-1:0]      w_join;
  logic [DATA_WD-1:0]      w_body_res;
  sum_t                    w_total;
  logic                    w_fits;
  logic [DATA_BYTE_WD-1:0] w_body_keep;
  logic [DATA_WD-1:0]      w_body_data;
  cnt_t                    w_spill_cnt;
  logic [DATA_BYTE_WD-1:0] w_flush_keep;
  logic [DATA_WD-1:0]      w_flush_data;

  always_comb begin
    w_out_free   = !r_valid_out || bus.ready_out;
    w_strip_n    = popcount(bus.keep_strip);
    w_in_cnt     = popcount(bus.keep_in);
    // Header beat: top n bytes go LSB-aligned to the header, the rest become residual.
    w_hdr_data   = bus.data_in >> (8 * (DATA_BYTE_WD - int'(r_n)));
    w_hdr_res    = bus.data_in << (8 * int'(r_n));
    w_hdr_cnt    = (w_in_cnt > r_n) ? (w_in_cnt - r_n) : '0;
    // Payload beat: residual on top, then as many input bytes as fit underneath.
    // The residual count is 0 for n=0 and n=DATA_BYTE_WD, which makes this a pass-through.
    w_join       = r_res | (bus.data_in >> (8 * int'(r_cnt)));
    w_body_res   = bus.data_in << (8 * (DATA_BYTE_WD - int'(r_cnt)));
    w_total      = {1'b0, r_cnt} + {1'b0, w_in_cnt};
    w_fits       = bus.last_in && (w_total <= FullSum);
    w_body_keep  = w_fits ? keep_of(cnt_t'(w_total)) : '1;
    w_body_data  = w_join & mask_of(w_body_keep);
    w_spill_cnt  = cnt_t'(w_total - FullSum);
    w_flush_keep = keep_of(r_cnt);
    w_flush_data = r_res & mask_of(w_flush_keep);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_ready_strip  <= 1'b0;
      r_n            <= '0;
      r_keep_strip   <= '0;
      r_res          <= '0;
      r_cnt          <= '0;
      r_valid_out    <= 1'b0;
      r_data_out     <= '0;
      r_keep_out     <= '0;
      r_last_out     <= 1'b0;
      r_header_out   <= '0;
      r_keep_header  <= '0;
      r_header_valid <= 1'b0;
    end else begin
      r_header_valid <= 1'b0;
      if (r_valid_out && bus.ready_out) r_valid_out <= 1'b0;

      unique case (r_state)
        StIdle: begin
          r_ready_strip <= 1'b1;
          if (bus.valid_strip && r_ready_strip) begin
            r_ready_strip <= 1'b0;
            r_n           <= w_strip_n;
            r_keep_strip  <= bus.keep_strip;
            r_res         <= '0;
            r_cnt         <= '0;
            r_state       <= (w_strip_n != '0) ? StHdr : StBody;
          end
        end

        StHdr: begin
          if (bus.valid_in) begin
            r_header_out   <= w_hdr_data;
            r_keep_header  <= r_keep_strip;
            r_header_valid <= 1'b1;
            r_res          <= w_hdr_res;
            r_cnt          <= w_hdr_cnt;
            if (!bus.last_in) begin
              r_state <= StBody;
            end else if (w_hdr_cnt != '0) begin
              r_state <= StFlush;
            end else begin
              r_state       <= StIdle;
              r_ready_strip <= 1'b1;
            end
          end
        end

        StBody: begin
          if (bus.valid_in && w_out_free) begin
            r_valid_out <= 1'b1;
            r_data_out  <= w_body_data;
            r_keep_out  <= w_body_keep;
            r_last_out  <= w_fits;
            r_res       <= w_body_res;
            if (w_fits) begin
              r_state       <= StIdle;
              r_ready_strip <= 1'b1;
            end else if (bus.last_in) begin
              // Last beat overflows the output word: leftover bytes go out in FLUSH.
              r_cnt   <= w_spill_cnt;
              r_state <= StFlush;
            end
          end
        end

        StFlush: begin
          if (w_out_free) begin
            r_valid_out   <= 1'b1;
            r_data_out    <= w_flush_data;
            r_keep_out    <= w_flush_keep;
            r_last_out    <= 1'b1;
            r_res         <= '0;
            r_cnt         <= '0;
            r_state       <= StIdle;
            r_ready_strip <= 1'b1;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  // ready_in must follow ready_out within the cycle to keep a single output stage
  // at full throughput, so it is decoded from state rather than registered.
  assign bus.ready_in     = (r_state == StHdr) || ((r_state == StBody) && w_out_free);
  assign bus.ready_strip  = r_ready_strip;
  assign bus.valid_out    = r_valid_out;
  assign bus.data_out     = r_data_out;
  assign bus.keep_out     = r_keep_out;
  assign bus.last_out     = r_last_out;
  assign bus.header_out   = r_header_out;
  assign bus.keep_header  = r_keep_header;
  assign bus.header_valid = r_header_valid;

endmodule

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, stream data width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), byte-count width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk (in, 1, rising-edge clock) first, then rst (in, 1, asynchronous active-high reset).
REQ-005 SHALL have valid_in, data_in, keep_in, last_in (in; 1, DATA_WD, DATA_BYTE_WD, 1): input AXI Stream carrying header plus payload.
REQ-006 SHALL have ready_in (out, 1): input stream ready.
REQ-007 SHALL have valid_out, data_out, keep_out, last_out (out; 1, DATA_WD, DATA_BYTE_WD, 1): payload stream with header removed.
REQ-008 SHALL have ready_out (in, 1): output stream ready.
REQ-009 SHALL have valid_strip (in, 1), keep_strip (in, DATA_BYTE_WD) and ready_strip (out, 1): per-packet header-length config; n = popcount(keep_strip); legal keep_strip values are 0000, 0001, 0011, 0111, 1111.
REQ-010 SHALL have header_out (out, DATA_WD), keep_header (out, DATA_BYTE_WD) and header_valid (out, 1): the extracted header, LSB-aligned.

Function
REQ-011 SHALL use MSB-first byte order: data[DATA_WD-1:DATA_WD-8] is the first byte on the wire; keep_in and keep_out are MSB-aligned contiguous.
REQ-012 SHALL implement states IDLE, HDR, BODY and FLUSH.
REQ-013 IDLE: ready_strip=1 and ready_in=0; on valid_strip&&ready_strip, latch n; go to HDR if n>0, or to BODY with an empty residual if n=0.
REQ-014 HDR: ready_in=1 and ready_strip=0.
REQ-015 On accepting the HDR beat, register the top n bytes of data_in into header_out[8n-1:0] (upper bytes 0) and keep_header=keep_strip, and pulse header_valid high for exactly one cycle on the next clock, without backpressure.
REQ-016 On the same HDR beat, store the lower DATA_BYTE_WD-n bytes as the residual, with valid-byte count from keep_in.
REQ-017 On the HDR beat, next state: last_in with an empty residual -> IDLE, emitting no payload beat; last_in with a non-empty residual -> FLUSH; otherwise -> BODY.
REQ-018 The output SHALL be a single register stage: ready_in in BODY = !valid_out || ready_out; data reaches valid_out 1 cycle after input acceptance.
REQ-019 BODY beat: data_out = {residual (DATA_BYTE_WD-n bytes), top n bytes of data_in}; the lower DATA_BYTE_WD-n bytes of data_in become the new residual.
REQ-020 BODY with last_in and m valid bytes, m <= n: emit one beat with last_out=1 and keep_out covering (DATA_BYTE_WD-n)+m bytes, then go to IDLE.
REQ-021 BODY with last_in and m valid bytes, m > n: emit a full beat with last_out=0, keep the m-n remaining bytes as the residual, and go to FLUSH.
REQ-022 FLUSH: ready_in=0; when the output register is free, emit the residual MSB-aligned with last_out=1 and matching keep_out, then go to IDLE.
REQ-023 With n=DATA_BYTE_WD the residual is always empty and payload beats pass through unchanged; with n=0 the packet passes unchanged and header_valid does not pulse.
REQ-024 valid_out, data_out, keep_out and last_out SHALL hold stable while valid_out&&!ready_out.
REQ-025 Unused data_out bytes (keep_out=0) SHALL be driven to 0.
REQ-026 Each packet consumes exactly one strip config; back-to-back packets each require a new config accepted in IDLE.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE; valid_out, last_out, header_valid, ready_in=0; data_out, keep_out, header_out, keep_header=0; residual cleared.
REQ-028 After rst deasserts, ready_strip=1 on the first clock.
REQ-029 Reset mid-packet SHALL drop the partial packet; no stale beat may appear after reset.

Verification
REQ-030 keep_strip=0011; beats 0xAABBCCDD, 0x11223344 (last, keep 1111) -> header_out=0x0000AABB, keep_header=0011, header_valid 1 cycle; out 0xCCDD1122 (keep 1111), then 0x33440000 (keep 1100, last).
REQ-031 keep_strip=0111; beats 0x01020304, 0x05060708 (last, keep 1000) -> header_out=0x00010203; single out 0x04050000, keep 1100, last.
REQ-032 keep_strip=1111; beats 0xDEADBEEF, 0xCAFEF00D (last) -> header_out=0xDEADBEEF; out 0xCAFEF00D, keep 1111, last; header-only packet (1 beat, last) -> no payload beat, return to IDLE.
REQ-033 keep_strip=0001, 4-beat packet, ready_out toggled 1-0-1 every cycle -> no beat lost or duplicated; output held stable while stalled; ready_strip=0 until the packet ends.
REQ-034 Assert rst for 1 cycle in BODY after 2 beats -> all outputs 0 immediately, ready_strip=1 the next cycle; the following packet is stripped correctly.
